// File: rtl/pu_riscv_ahb3_pkg.sv
// AHB3-Lite encodings, BIU state type and data-phase bundle.
// Imported by the BIU top and its next-address helper.
package pu_riscv_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NONSEQ,
    ST_SEQ,
    ST_ERR
  } biu_state_t;

  typedef struct packed {
    logic valid;
    logic we;
  } dphase_t;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] n;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
      default:                      n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pu_riscv_biu_nxt_adr.sv
// Next beat address for AHB bursts.
// INCR steps by the transfer size; WRAP folds inside the burst window.
module pu_riscv_biu_nxt_adr
  import pu_riscv_ahb3_pkg::*;
#(
  parameter int PLEN = 64
) (
  input  logic [PLEN-1:0] adr,
  input  logic [2:0]      size,
  input  logic [2:0]      burst,
  output logic [PLEN-1:0] nxt
);

  logic [PLEN-1:0] bytes;
  logic [PLEN-1:0] inc;
  logic [PLEN-1:0] mask;
  logic            wrap;

  always_comb begin
    bytes = PLEN'(1) << size;
    inc   = adr + bytes;
    mask  = '0;
    wrap  = 1'b1;
    unique case (burst)
      HBURST_WRAP4:  mask = (bytes << 2) - PLEN'(1);
      HBURST_WRAP8:  mask = (bytes << 3) - PLEN'(1);
      HBURST_WRAP16: mask = (bytes << 4) - PLEN'(1);
      default:       wrap = 1'b0;
    endcase
    nxt = wrap ? ((adr & ~mask) | (inc & mask)) : inc;
  end

endmodule

// File: rtl/pu_riscv_biu_ahb3.sv
// Bus interface unit: stb/ack requests to an AHB3-Lite master port.
// Optional HREADY watchdog: PU_RISCV_BIU_HREADY_TIMEOUT_EN.
module pu_riscv_biu_ahb3
  import pu_riscv_ahb3_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            biu_stb_i,
  output logic            biu_stb_ack_o,
  output logic            biu_d_ack_o,
  input  logic [PLEN-1:0] biu_adri_i,
  output logic [PLEN-1:0] biu_adro_o,
  input  logic [2:0]      biu_size_i,
  input  logic [2:0]      biu_type_i,
  input  logic            biu_lock_i,
  input  logic [2:0]      biu_prot_i,
  input  logic            biu_we_i,
  input  logic [XLEN-1:0] biu_d_i,
  output logic [XLEN-1:0] biu_q_o,
  output logic            biu_ack_o,
  output logic            biu_err_o,

  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic            HREADY,
  input  logic            HRESP
);

  biu_state_t      state_q, state_d;
  logic [PLEN-1:0] adr_q, adr_d, nxt_adr;
  logic [2:0]      size_q, size_d;
  logic [2:0]      burst_q, burst_d;
  logic [2:0]      prot_q, prot_d;
  logic            we_q, we_d;
  logic            lock_q, lock_d;
  logic [3:0]      cnt_q, cnt_d;
  dphase_t         dph_q, dph_d;
  logic [XLEN-1:0] wdat_q, wdat_d;

  logic            addr_act;
  logic            addr_done;
  logic            err_start;
  logic            take;
  logic [4:0]      beats;

  pu_riscv_biu_nxt_adr #(
    .PLEN (PLEN)
  ) u_nxt_adr (
    .adr   (adr_q),
    .size  (size_q),
    .burst (burst_q),
    .nxt   (nxt_adr)
  );

  assign addr_act  = (state_q == ST_NONSEQ) || (state_q == ST_SEQ);
  assign addr_done = addr_act && HREADY;
  // First cycle of a two-cycle ERROR response
  assign err_start = dph_q.valid && !HREADY && (HRESP == HRESP_ERROR);
  assign beats     = burst_beats(biu_type_i);

`ifdef PU_RISCV_BIU_HREADY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = dph_q.valid && !HREADY &&
                   (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = '0;
    if (dph_q.valid && !HREADY && !tmo_hit)
      tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    size_d        = size_q;
    burst_d       = burst_q;
    prot_d        = prot_q;
    we_d          = we_q;
    lock_d        = lock_q;
    cnt_d         = cnt_q;
    dph_d         = dph_q;
    wdat_d        = wdat_q;
    take          = 1'b0;
    biu_stb_ack_o = 1'b0;
    biu_d_ack_o   = 1'b0;
    biu_ack_o     = 1'b0;
    biu_err_o     = 1'b0;

    if (dph_q.valid && HREADY) begin
      biu_ack_o = (HRESP == HRESP_OKAY);
      biu_err_o = (HRESP == HRESP_ERROR);
    end

    if (HREADY) begin
      dph_d.valid = addr_done;
      dph_d.we    = addr_done && we_q;
    end

    if (addr_done && we_q) begin
      wdat_d      = biu_d_i;
      biu_d_ack_o = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (err_start)               state_d = ST_ERR;
        else if (biu_stb_i && HREADY) take   = 1'b1;
      end
      ST_NONSEQ, ST_SEQ: begin
        if (err_start) begin
          state_d = ST_ERR;
          lock_d  = 1'b0;
        end else if (HREADY) begin
          if (cnt_q != '0) begin
            state_d = ST_SEQ;
            adr_d   = nxt_adr;
            cnt_d   = cnt_q - 4'd1;
          end else if (biu_stb_i) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            lock_d  = 1'b0;
          end
        end
      end
      ST_ERR: begin
        if (!(dph_q.valid && !HREADY)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      state_d       = ST_NONSEQ;
      adr_d         = biu_adri_i;
      size_d        = biu_size_i;
      burst_d       = biu_type_i;
      prot_d        = biu_prot_i;
      we_d          = biu_we_i;
      lock_d        = biu_lock_i;
      cnt_d         = 4'(beats - 5'd1);
      biu_stb_ack_o = 1'b1;
    end

`ifdef PU_RISCV_BIU_HREADY_TIMEOUT_EN
    // Abandon the stalled beat; a late HREADY is no longer ours
    if (tmo_hit) begin
      biu_err_o = 1'b1;
      dph_d     = '0;
      state_d   = ST_ERR;
      lock_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      we_q    <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      dph_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      we_q    <= we_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      dph_q   <= dph_d;
      wdat_q  <= wdat_d;
    end
  end

  always_comb begin
    HTRANS = HTRANS_IDLE;
    unique case (1'b1)
      state_q == ST_NONSEQ: HTRANS = HTRANS_NONSEQ;
      state_q == ST_SEQ:    HTRANS = HTRANS_SEQ;
      default:              HTRANS = HTRANS_IDLE;
    endcase
  end

  assign HSEL       = addr_act;
  assign HADDR      = adr_q;
  assign HWRITE     = we_q;
  assign HSIZE      = size_q;
  assign HBURST     = burst_q;
  assign HPROT      = {prot_q[2], 1'b0, prot_q[1], prot_q[0]};
  assign HMASTLOCK  = lock_q;
  assign HWDATA     = dph_q.we ? wdat_q : '0;
  assign biu_adro_o = adr_q;
  assign biu_q_o    = HRDATA;

endmodule

// File: tb/tb_pu_riscv_biu_ahb3.sv
// Directed bench for pu_riscv_biu_ahb3.
// Expected values are hand-derived per cycle.
module tb_pu_riscv_biu_ahb3;
  import pu_riscv_ahb3_pkg::*;

  localparam int XLEN = 64;
  localparam int PLEN = 64;
`ifdef PU_RISCV_BIU_HREADY_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            biu_stb_i;
  logic            biu_stb_ack_o;
  logic            biu_d_ack_o;
  logic [PLEN-1:0] biu_adri_i;
  logic [PLEN-1:0] biu_adro_o;
  logic [2:0]      biu_size_i;
  logic [2:0]      biu_type_i;
  logic            biu_lock_i;
  logic [2:0]      biu_prot_i;
  logic            biu_we_i;
  logic [XLEN-1:0] biu_d_i;
  logic [XLEN-1:0] biu_q_o;
  logic            biu_ack_o;
  logic            biu_err_o;
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HRESP;

  int n_run  = 0;
  int n_fail = 0;

  logic [63:0] wd   [4];
  logic [63:0] wrap [4];

  pu_riscv_biu_ahb3 #(
    .XLEN    (XLEN),
    .PLEN    (PLEN),
    .TIMEOUT (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .biu_stb_i     (biu_stb_i),
    .biu_stb_ack_o (biu_stb_ack_o),
    .biu_d_ack_o   (biu_d_ack_o),
    .biu_adri_i    (biu_adri_i),
    .biu_adro_o    (biu_adro_o),
    .biu_size_i    (biu_size_i),
    .biu_type_i    (biu_type_i),
    .biu_lock_i    (biu_lock_i),
    .biu_prot_i    (biu_prot_i),
    .biu_we_i      (biu_we_i),
    .biu_d_i       (biu_d_i),
    .biu_q_o       (biu_q_o),
    .biu_ack_o     (biu_ack_o),
    .biu_err_o     (biu_err_o),
    .HSEL          (HSEL),
    .HADDR         (HADDR),
    .HWDATA        (HWDATA),
    .HRDATA        (HRDATA),
    .HWRITE        (HWRITE),
    .HSIZE         (HSIZE),
    .HBURST        (HBURST),
    .HPROT         (HPROT),
    .HTRANS        (HTRANS),
    .HMASTLOCK     (HMASTLOCK),
    .HREADY        (HREADY),
    .HRESP         (HRESP)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic req(input logic [63:0] a, input logic [2:0] sz,
                     input logic [2:0] bt, input logic we,
                     input logic lk, input logic [2:0] pr);
    biu_stb_i  = 1'b1;
    biu_adri_i = a;
    biu_size_i = sz;
    biu_type_i = bt;
    biu_we_i   = we;
    biu_lock_i = lk;
    biu_prot_i = pr;
  endtask

  initial begin
    biu_stb_i = 0; biu_adri_i = '0; biu_size_i = '0;
    biu_type_i = '0; biu_lock_i = 0; biu_prot_i = '0;
    biu_we_i = 0; biu_d_i = '0; HRDATA = '0;
    HREADY = 1; HRESP = 0;
    wd[0] = 64'h0000_0000_A0A0_0000;
    wd[1] = 64'h0000_0000_B1B1_0001;
    wd[2] = 64'h0000_0000_C2C2_0002;
    wd[3] = 64'h0000_0000_D3D3_0003;
    wrap[0] = 64'h3008; wrap[1] = 64'h300C;
    wrap[2] = 64'h3000; wrap[3] = 64'h3004;

    // reset values
    mid();
    check("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("rst_hsel", 64'(HSEL), 64'd0);
    check("rst_haddr", 64'(HADDR), 64'd0);
    check("rst_ack", 64'(biu_ack_o), 64'd0);
    check("rst_lock", 64'(HMASTLOCK), 64'd0);
    tick(); rst_ni = 1;

    // single read
    req(64'h1000, HSIZE_DWORD, HBURST_SINGLE, 0, 0, 3'b011);
    mid();
    check("s_stb_ack", 64'(biu_stb_ack_o), 64'd1);
    check("s_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    tick(); biu_stb_i = 0;
    mid();
    check("s_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
    check("s_haddr", 64'(HADDR), 64'h1000);
    check("s_hprot", 64'(HPROT), 64'h3);
    check("s_hsel", 64'(HSEL), 64'd1);
    check("s_ack_early", 64'(biu_ack_o), 64'd0);
    tick(); HRDATA = 64'hDEAD_BEEF_CAFE_F00D;
    mid();
    check("s_ack", 64'(biu_ack_o), 64'd1);
    check("s_q", 64'(biu_q_o), 64'hDEAD_BEEF_CAFE_F00D);
    check("s_end_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    tick();
    mid();
    check("s_ack_gone", 64'(biu_ack_o), 64'd0);

    // INCR4 write, two wait states on the second beat
    tick();
    req(64'h2000, HSIZE_WORD, HBURST_INCR4, 1, 0, 3'b001);
    biu_d_i = wd[0];
    mid();
    check("w_stb_ack", 64'(biu_stb_ack_o), 64'd1);
    tick(); biu_stb_i = 0;
    mid();
    check("w_a0", 64'(HADDR), 64'h2000);
    check("w_hwrite", 64'(HWRITE), 64'd1);
    check("w_dack0", 64'(biu_d_ack_o), 64'd1);
    check("w_ack_early", 64'(biu_ack_o), 64'd0);
    tick(); biu_d_i = wd[1];
    mid();
    check("w_a1", 64'(HADDR), 64'h2004);
    check("w_seq", 64'(HTRANS), 64'(HTRANS_SEQ));
    check("w_ack0", 64'(biu_ack_o), 64'd1);
    check("w_wd0", 64'(HWDATA), wd[0]);
    check("w_dack1", 64'(biu_d_ack_o), 64'd1);
    tick(); biu_d_i = wd[2]; HREADY = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      mid();
      check("w_wait_a", 64'(HADDR), 64'h2008);
      check("w_wait_wd", 64'(HWDATA), wd[1]);
      check("w_wait_ack", 64'(biu_ack_o), 64'd0);
      check("w_wait_dack", 64'(biu_d_ack_o), 64'd0);
    end
    tick(); HREADY = 1;
    mid();
    check("w_a2", 64'(HADDR), 64'h2008);
    check("w_ack1", 64'(biu_ack_o), 64'd1);
    check("w_dack2", 64'(biu_d_ack_o), 64'd1);
    tick(); biu_d_i = wd[3];
    mid();
    check("w_a3", 64'(HADDR), 64'h200C);
    check("w_wd2", 64'(HWDATA), wd[2]);
    check("w_ack2", 64'(biu_ack_o), 64'd1);
    check("w_dack3", 64'(biu_d_ack_o), 64'd1);
    tick();
    mid();
    check("w_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("w_wd3", 64'(HWDATA), wd[3]);
    check("w_ack3", 64'(biu_ack_o), 64'd1);
    check("w_no_dack", 64'(biu_d_ack_o), 64'd0);

    // WRAP4 read, then a locked single back-to-back
    tick();
    req(64'h3008, HSIZE_WORD, HBURST_WRAP4, 0, 0, 3'b000);
    mid();
    check("r_stb_ack", 64'(biu_stb_ack_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) req(64'h4000, HSIZE_DWORD, HBURST_SINGLE, 0, 1, 3'b000);
      else        biu_stb_i = 0;
      mid();
      check("r_wrap_a", 64'(HADDR), wrap[i]);
      check("r_wrap_t", 64'(HTRANS),
            64'((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ));
      check("r_hburst", 64'(HBURST), 64'(HBURST_WRAP4));
    end
    check("b2b_stb_ack", 64'(biu_stb_ack_o), 64'd1);
    tick(); biu_stb_i = 0;
    mid();
    check("b2b_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
    check("b2b_addr", 64'(HADDR), 64'h4000);
    check("b2b_lock", 64'(HMASTLOCK), 64'd1);
    tick();
    mid();
    check("b2b_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("b2b_unlock", 64'(HMASTLOCK), 64'd0);
    check("b2b_ack", 64'(biu_ack_o), 64'd1);

    // INCR8 read, ERROR on the third beat
    tick();
    req(64'h5000, HSIZE_DWORD, HBURST_INCR8, 0, 0, 3'b000);
    mid();
    tick(); biu_stb_i = 0;
    mid();
    check("e_a0", 64'(HADDR), 64'h5000);
    tick();
    mid();
    check("e_a1", 64'(HADDR), 64'h5008);
    check("e_ack0", 64'(biu_ack_o), 64'd1);
    tick();
    mid();
    check("e_ack1", 64'(biu_ack_o), 64'd1);
    tick(); HREADY = 0; HRESP = 1;
    mid();
    check("e_a3", 64'(HADDR), 64'h5018);
    check("e_err_early", 64'(biu_err_o), 64'd0);
    tick(); HREADY = 1;
    mid();
    check("e_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("e_err", 64'(biu_err_o), 64'd1);
    check("e_ack_none", 64'(biu_ack_o), 64'd0);
    tick(); HRESP = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      mid();
      check("e_after_err", 64'(biu_err_o), 64'd0);
      check("e_after_ack", 64'(biu_ack_o), 64'd0);
      check("e_after_t", 64'(HTRANS), 64'(HTRANS_IDLE));
    end

    // reset during a locked INCR4 read
    tick();
    req(64'h6000, HSIZE_WORD, HBURST_INCR4, 0, 1, 3'b000);
    mid();
    tick(); biu_stb_i = 0;
    mid();
    check("x_lock", 64'(HMASTLOCK), 64'd1);
    tick();
    mid();
    check("x_seq_a", 64'(HADDR), 64'h6004);
    #1 rst_ni = 0;
    #1;
    check("x_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("x_hsel", 64'(HSEL), 64'd0);
    check("x_haddr", 64'(HADDR), 64'd0);
    check("x_lock0", 64'(HMASTLOCK), 64'd0);
    check("x_ack", 64'(biu_ack_o), 64'd0);
    tick(); rst_ni = 1;
    req(64'h7000, HSIZE_DWORD, HBURST_SINGLE, 1, 0, 3'b000);
    biu_d_i = 64'h1111_2222_3333_4444;
    mid();
    check("x_stb_ack", 64'(biu_stb_ack_o), 64'd1);
    tick(); biu_stb_i = 0;
    mid();
    check("x_nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
    check("x_addr", 64'(HADDR), 64'h7000);
    check("x_dack", 64'(biu_d_ack_o), 64'd1);
    tick();
    mid();
    check("x_wd", 64'(HWDATA), 64'h1111_2222_3333_4444);
    check("x_wack", 64'(biu_ack_o), 64'd1);

    // HREADY stuck low in a data phase
    tick();
    req(64'h8000, HSIZE_DWORD, HBURST_SINGLE, 0, 0, 3'b000);
    mid();
    tick(); biu_stb_i = 0;
    mid();
    for (int i = 0; i < 5; i++) begin
      tick(); HREADY = 0;
      mid();
      check("t_err", 64'(biu_err_o), 64'(TMO_EN && (i == 3)));
    end
    tick(); HREADY = 1;
    mid();
    check("t_late_ack", 64'(biu_ack_o), 64'(!TMO_EN));
    check("t_late_err", 64'(biu_err_o), 64'd0);
    tick();
    mid();
    check("t_idle", 64'(HTRANS), 64'(HTRANS_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
